// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) arbiter onto one main-memory port, one transaction in flight.
// Default: data priority with an instruction starvation guard; define ARB_ROUND_ROBIN_EN for round-robin.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        res,
    input  logic        instr_req,
    input  logic [31:0] instr_adr,
    output logic        instr_gnt,
    output logic        instr_rvalid,
    output logic [31:0] instr_read,
    input  logic        data_req,
    input  logic [31:0] data_adr,
    input  logic        data_we,
    input  logic [3:0]  data_be,
    input  logic [31:0] data_wdata,
    output logic        data_gnt,
    output logic        data_rvalid,
    output logic [31:0] data_read,
    output logic        mem_req,
    output logic [31:0] mem_adr,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_read
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    localparam logic OWN_DATA  = 1'b0;
    localparam logic OWN_INSTR = 1'b1;

    logic [1:0] state, state_nxt;
    logic       owner, owner_nxt;
    logic       pick_instr;
    logic       own_i;

`ifndef ARB_ROUND_ROBIN_EN
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
    logic [3:0] starve, starve_nxt;
`endif

    // Winner selection; only meaningful while IDLE
    always_comb begin
        pick_instr = 1'b0;
`ifndef ARB_ROUND_ROBIN_EN
        starve_nxt = starve;
`endif
        if (instr_req && !data_req) begin
            pick_instr = 1'b1;
        end else if (instr_req && data_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            // owner still holds the previous transaction's port while IDLE
            pick_instr = (owner == OWN_DATA);
`else
            pick_instr = (starve == STARVE_MAX);
`endif
        end
`ifndef ARB_ROUND_ROBIN_EN
        if (state == S_IDLE && instr_req) begin
            if (pick_instr)
                starve_nxt = 4'd0;
            else if (starve < STARVE_MAX)
                starve_nxt = starve + 4'd1;
        end
`endif
    end

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        case (state)
            S_IDLE: begin
                if (instr_req || data_req) begin
                    state_nxt = S_REQ;
                    owner_nxt = pick_instr ? OWN_INSTR : OWN_DATA;
                end
            end
            S_REQ:   if (mem_gnt)    state_nxt = S_WAIT;
            S_WAIT:  if (mem_rvalid) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state <= S_IDLE;
            owner <= OWN_DATA;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
        end
    end

`ifndef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or negedge res) begin
        if (!res) starve <= 4'd0;
        else      starve <= starve_nxt;
    end
`endif

    assign own_i = (owner == OWN_INSTR);

    assign mem_req   = (state == S_REQ);
    assign mem_adr   = own_i ? instr_adr : data_adr;
    assign mem_we    = own_i ? 1'b0      : data_we;
    assign mem_be    = own_i ? 4'hF      : data_be;
    assign mem_wdata = own_i ? 32'd0     : data_wdata;

    assign instr_gnt    = (state == S_REQ)  &&  own_i && mem_gnt;
    assign data_gnt     = (state == S_REQ)  && !own_i && mem_gnt;
    assign instr_rvalid = (state == S_WAIT) &&  own_i && mem_rvalid;
    assign data_rvalid  = (state == S_WAIT) && !own_i && mem_rvalid;

    assign instr_read = mem_read;
    assign data_read  = mem_read;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table with read-data scoreboard plus arbitration/reset sequences.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        res;
    logic        instr_req, instr_gnt, instr_rvalid;
    logic [31:0] instr_adr, instr_read;
    logic        data_req, data_we, data_gnt, data_rvalid;
    logic [31:0] data_adr, data_wdata, data_read;
    logic [3:0]  data_be;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0] mem_adr, mem_wdata, mem_read;
    logic [3:0]  mem_be;

    int checks   = 0;
    int failures = 0;

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .res(res),
        .instr_req(instr_req), .instr_adr(instr_adr), .instr_gnt(instr_gnt),
        .instr_rvalid(instr_rvalid), .instr_read(instr_read),
        .data_req(data_req), .data_adr(data_adr), .data_we(data_we), .data_be(data_be),
        .data_wdata(data_wdata), .data_gnt(data_gnt), .data_rvalid(data_rvalid),
        .data_read(data_read),
        .mem_req(mem_req), .mem_adr(mem_adr), .mem_we(mem_we), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_read(mem_read)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_instr;
        logic [31:0] adr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          gnt_dly;
        int          rv_dly;
    } vec_t;

    typedef struct {
        logic        is_instr;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[5];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic do_reset();
        res = 1'b0;
        #1;
        step();
        step();
        res = 1'b1;
    endtask

    // Drives one single-port transaction and plays the memory side; starts and ends in IDLE.
    task automatic run_vec(input vec_t v, input string tag);
        logic [31:0] e_adr, e_wdata;
        logic        e_we;
        logic [3:0]  e_be;
        logic        hold_ok, quiet_ok;
        exp_t        e;
        e_adr   = v.adr;
        e_we    = v.is_instr ? 1'b0  : v.we;
        e_be    = v.is_instr ? 4'hF  : v.be;
        e_wdata = v.is_instr ? 32'd0 : v.wdata;
        instr_req  = v.is_instr;
        data_req   = !v.is_instr;
        instr_adr  = v.is_instr ? v.adr : 32'hAAAA_5555;
        data_adr   = v.is_instr ? 32'h5555_AAAA : v.adr;
        data_we    = v.we;
        data_be    = v.be;
        data_wdata = v.wdata;
        e.is_instr = v.is_instr;
        e.rdata    = v.rdata;
        sb.push_back(e);
        step();
        check({tag, "_latency"}, mem_req, 1);
        check({tag, "_adr"}, mem_adr, e_adr);
        check({tag, "_we"}, mem_we, e_we);
        check({tag, "_be"}, mem_be, e_be);
        check({tag, "_wdata"}, mem_wdata, e_wdata);
        hold_ok  = 1'b1;
        quiet_ok = 1'b1;
        for (int n = 0; n < v.gnt_dly; n++) begin
            mem_rvalid = 1'b1;
            mem_read   = 32'hBAD0_0000;
            #1;
            if (!mem_req || mem_adr !== e_adr || instr_gnt || data_gnt || instr_rvalid || data_rvalid)
                hold_ok = 1'b0;
            step();
        end
        mem_rvalid = 1'b0;
        #1;
        check({tag, "_hold"}, {31'd0, hold_ok}, 1);
        mem_gnt = 1'b1;
        #1;
        check({tag, "_own_gnt"}, v.is_instr ? instr_gnt : data_gnt, 1);
        if (v.is_instr ? data_gnt : instr_gnt) quiet_ok = 1'b0;
        step();
        mem_gnt   = 1'b0;
        instr_req = 1'b0;
        data_req  = 1'b0;
        for (int n = 0; n < v.rv_dly; n++) begin
            mem_gnt = 1'b1;
            #1;
            if (mem_req || instr_gnt || data_gnt || instr_rvalid || data_rvalid) quiet_ok = 1'b0;
            step();
            mem_gnt = 1'b0;
        end
        mem_rvalid = 1'b1;
        mem_read   = v.rdata;
        #1;
        check({tag, "_rv_seen"}, {31'd0, instr_rvalid | data_rvalid}, 1);
        if (instr_rvalid && data_rvalid) quiet_ok = 1'b0;
        if ((instr_rvalid || data_rvalid) && sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_rv_port"}, {31'd0, instr_rvalid}, {31'd0, e.is_instr});
            check({tag, "_rv_data"}, e.is_instr ? instr_read : data_read, e.rdata);
        end
        step();
        mem_rvalid = 1'b0;
        #1;
        check({tag, "_quiet"}, {31'd0, quiet_ok}, 1);
        check({tag, "_idle_gap"}, mem_req, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [9:0] got_i, exp_i;
        int grants, cyc;
        logic pend;

        vecs[0] = '{1'b1, 32'h0000_0040, 1'b1, 4'b0101, 32'h1111_2222, 32'hDEAD_BEEF, 2, 0};
        vecs[1] = '{1'b0, 32'h0000_0100, 1'b1, 4'b0011, 32'h1234_5678, 32'h0000_0000, 0, 1};
        vecs[2] = '{1'b0, 32'h2000_0004, 1'b0, 4'hF,    32'hFFFF_FFFF, 32'hCAFE_F00D, 1, 2};
        vecs[3] = '{1'b1, 32'h8000_0000, 1'b0, 4'h0,    32'h0,         32'h0BAD_C0DE, 20, 0};
        vecs[4] = '{1'b0, 32'h0000_0FFC, 1'b1, 4'b1000, 32'hA5A5_5A5A, 32'h7777_0001, 3, 3};

        // reset holds everything quiet even with all inputs active
        res = 1'b0;
        instr_req = 1'b1; data_req = 1'b1;
        instr_adr = 32'h10; data_adr = 32'h20; data_we = 1'b1; data_be = 4'hF; data_wdata = 32'h0;
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_read = 32'h0;
        step();
        step();
        check("rst_outputs",
              {27'd0, mem_req, instr_gnt, instr_rvalid, data_gnt, data_rvalid}, 0);
        instr_req = 1'b0; data_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        res = 1'b1;

        for (int k = 0; k < 5; k++)
            run_vec(vecs[k], $sformatf("vec%0d", k));
        check("sb_empty", sb.size(), 0);

        // both ports requesting continuously
        do_reset();
        instr_req = 1'b1; data_req = 1'b1;
        instr_adr = 32'h400; data_adr = 32'h800;
        got_i = '0; grants = 0; cyc = 0; pend = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        exp_i = 10'b1010101010;
`else
        exp_i = 10'b0000100001;
`endif
        while (grants < 10 && cyc < 200) begin
            mem_gnt    = mem_req;
            mem_rvalid = pend;
            #1;
            if (instr_gnt || data_gnt) begin
                got_i[9 - grants] = instr_gnt;
                grants++;
            end
            pend = mem_gnt;
            step();
            cyc++;
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        instr_req = 1'b0; data_req = 1'b0;
        check("arb_grants", grants, 10);
        for (int k = 0; k < 10; k++)
            check($sformatf("arb_order%0d", k), {31'd0, got_i[9 - k]}, {31'd0, exp_i[9 - k]});
        pend = 1'b1;
        mem_rvalid = pend;
        step();
        mem_rvalid = 1'b0;

        // reset while waiting for rvalid, then a late rvalid after release
        do_reset();
        instr_req = 1'b1; instr_adr = 32'h44;
        step();
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0; instr_req = 1'b0;
        mem_rvalid = 1'b1; mem_read = 32'h5EED_0000;
        #1;
        check("wait_rvalid_pre", instr_rvalid, 1);
        res = 1'b0;
        #1;
        check("rst_async",
              {27'd0, mem_req, instr_gnt, instr_rvalid, data_gnt, data_rvalid}, 0);
        mem_rvalid = 1'b0;
        step();
        res = 1'b1;
        step();
        mem_rvalid = 1'b1;
        #1;
        check("late_rvalid", {30'd0, instr_rvalid, data_rvalid}, 0);
        step();
        mem_rvalid = 1'b0;
        check("late_idle", mem_req, 0);
        run_vec(vecs[0], "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
